// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
//
// Two-requester arbiter/sequencer for the shared WIDTH-bit mux2 datapath.
// Drives the mux2 selection input and registers the selected word into a
// single output stage with valid/ready handshaking. Ties are broken
// round-robin and a granted requester may stream up to MAX_BURST beats.
//
// Optional build macro:
//   MUX_ARB_FIXED_PRIO_EN  defined   -> fixed priority, A over B (B may starve)
//                          undefined -> round-robin using the 'last' register
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   a_valid    in   1      requester A has data
//   a_data     in   WIDTH  requester A word (mux2 input A, selection=0)
//   a_ready    out  1      A beat accepted this cycle
//   b_valid    in   1      requester B has data
//   b_data     in   WIDTH  requester B word (mux2 input B, selection=1)
//   b_ready    out  1      B beat accepted this cycle
//   sel        out  1      mux2 selection (0 in GNT_A, 1 in GNT_B, held in IDLE)
//   out_valid  out  1      output register holds a word
//   out_data   out  WIDTH  registered mux2 output
//   out_ready  in   1      consumer accepts out_data
//   busy       out  1      arbiter is not idle
// -----------------------------------------------------------------------------

// Plain 2:1 word multiplexer shared by both producers.
module mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             selection,
  output logic [WIDTH-1:0] result
);
  assign result = selection ? b : a;
endmodule

module mux2_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_sel;
  req_e             r_last;
  logic [CW-1:0]    r_burst_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic [WIDTH-1:0] w_mux_out;
  logic             w_out_free;
  logic             w_acc_a;
  logic             w_acc_b;
  logic             w_accept;
  logic             w_release;
  logic             w_clear_cnt;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_burst_done;
  state_e           w_idle_pick;
  state_e           w_rel_a;
  state_e           w_rel_b;

  mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .a         (a_data),
    .b         (b_data),
    .selection (r_sel),
    .result    (w_mux_out)
  );

  // Output stage can take a new beat when empty or being drained this cycle.
  assign w_out_free   = !r_out_valid || out_ready;
  assign w_cnt_inc    = r_burst_cnt + CW'(1);
  assign w_burst_done = (w_cnt_inc == CW'(MAX_BURST));

  // Grant choice from IDLE and on release from either grant state.
  always_comb begin
    w_idle_pick = ST_IDLE;
    w_rel_a     = ST_IDLE;
    w_rel_b     = ST_IDLE;
`ifdef MUX_ARB_FIXED_PRIO_EN
    if (a_valid)      w_idle_pick = ST_GNT_A;
    else if (b_valid) w_idle_pick = ST_GNT_B;
    w_rel_a = w_idle_pick;
    w_rel_b = w_idle_pick;
`else
    unique case ({a_valid, b_valid})
      2'b11:   w_idle_pick = (r_last == REQ_B) ? ST_GNT_A : ST_GNT_B;
      2'b10:   w_idle_pick = ST_GNT_A;
      2'b01:   w_idle_pick = ST_GNT_B;
      default: w_idle_pick = ST_IDLE;
    endcase
    // Releasing requester yields to the other; it only re-enters on its
    // own when the other side is idle (burst expiry with valid still high).
    if (b_valid)      w_rel_a = ST_GNT_B;
    else if (a_valid) w_rel_a = ST_GNT_A;
    if (a_valid)      w_rel_b = ST_GNT_A;
    else if (b_valid) w_rel_b = ST_GNT_B;
`endif
  end

  // Next state, accept and release.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_a     = 1'b0;
    w_acc_b     = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = w_idle_pick;
      end
      ST_GNT_A: begin
        w_acc_a   = a_valid && w_out_free;
        w_release = !a_valid || (w_acc_a && w_burst_done);
        if (w_release) w_state_nxt = w_rel_a;
      end
      ST_GNT_B: begin
        w_acc_b   = b_valid && w_out_free;
        w_release = !b_valid || (w_acc_b && w_burst_done);
        if (w_release) w_state_nxt = w_rel_b;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept    = w_acc_a || w_acc_b;
  // Counter restarts on every grant entry, including re-entry after expiry.
  assign w_clear_cnt = (r_state == ST_IDLE) || w_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= 1'b0;
      r_last      <= REQ_B;
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;

      // sel tracks the grant and holds its value through IDLE.
      if (w_state_nxt == ST_GNT_A)      r_sel <= 1'b0;
      else if (w_state_nxt == ST_GNT_B) r_sel <= 1'b1;

      if (w_release) r_last <= (r_state == ST_GNT_B) ? REQ_B : REQ_A;

      if (w_clear_cnt)   r_burst_cnt <= '0;
      else if (w_accept) r_burst_cnt <= w_cnt_inc;

      if (w_accept) begin
        r_out_data  <= w_mux_out;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign a_ready   = w_acc_a;
  assign b_ready   = w_acc_b;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != ST_IDLE);

endmodule
